// File: rtl/dependency_loopback_tester_if.sv
// ---------------------------------------------------------------------------
// veryl_sample3_data_if
//   Single data bus shared between a stimulus driver and the delay chains
//   under test.
//   mp_out : the driver writes data
//   mp_in  : the observer reads data
// ---------------------------------------------------------------------------
interface veryl_sample3_data_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data;

   modport mp_out (output data);
   modport mp_in  (input  data);
endinterface

// File: rtl/dependency_loopback_tester.sv
// ---------------------------------------------------------------------------
// dependency_loopback_tester
//   Drives a data stream into a delay pipeline through tx_if and watches the
//   pipeline output on rx_if. The sequence is:
//     1. flush zeros through the pipeline,
//     2. send a one-cycle all-ones SYNC word and count cycles until it returns,
//        which gives the round-trip latency,
//     3. stream CHECK_LEN LFSR words and compare each returned word with the
//        value that was sent latency cycles earlier, counting mismatches.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_start    one-cycle start request; only accepted in IDLE or DONE
//   tx_if      stimulus bus (registered data)
//   rx_if      returned bus from the pipeline
//   o_busy     high in FLUSH/MEASURE/RUN/DRAIN
//   o_done     high in DONE
//   o_pass     result, meaningful while o_done is high
//   o_latency  measured latency; all-ones when SYNC never came back
//   o_err_cnt  mismatch count, saturating at 0xFFFF
//
// Build option
//   DEPENDENCY_LOOPBACK_TESTER_LAT_CHECK_EN : when defined, o_pass also
//   requires o_latency == EXP_LAT.
// ---------------------------------------------------------------------------
module dependency_loopback_tester #(
   parameter int WIDTH     = 8,
   parameter int MAX_LAT   = 15,
   parameter int EXP_LAT   = 2,
   parameter int SEED      = 1,
   parameter int CHECK_LEN = 256,
   localparam int LW       = $clog2(MAX_LAT + 2)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   veryl_sample3_data_if.mp_out tx_if,
   veryl_sample3_data_if.mp_in  rx_if,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic [LW-1:0]        o_latency,
   output logic [15:0]          o_err_cnt
);

`ifdef DEPENDENCY_LOOPBACK_TESTER_LAT_CHECK_EN
   localparam bit LAT_CHECK = 1'b1;
`else
   localparam bit LAT_CHECK = 1'b0;
`endif

   localparam int               CW     = $clog2(CHECK_LEN + 1);
   localparam logic [WIDTH-1:0] SYNC   = '1;
   localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

   typedef enum logic [2:0] {IDLE, FLUSH, MEASURE, RUN, DRAIN, DONE} state_t;

   state_t                      state, state_nxt;
   // hist[0] is the tx_if.data register itself; hist[k] is the value k cycles
   // earlier. vld_pipe marks which entries carry LFSR words.
   logic [MAX_LAT:0][WIDTH-1:0] hist;
   logic [MAX_LAT:0]            vld_pipe;
   logic [WIDTH-1:0]            tx_nxt, lfsr, lfsr_nxt, rx_sel;
   logic                        vld_nxt, rx_vld, fb, sync_seen, mismatch;
   logic [LW-1:0]               cnt;
   logic [CW-1:0]               wcnt;

   assign tx_if.data = hist[0];
   assign sync_seen  = (rx_if.data == SYNC);

   // Fibonacci LFSR, shifting toward the MSB
   if (WIDTH == 16) begin : g_p16
      assign fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
   end else if (WIDTH == 32) begin : g_p32
      assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
   end else begin : g_p8
      assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   end
   assign lfsr_nxt = {lfsr[WIDTH-2:0], fb};

   // Pick the history tap that lines up with the measured latency
   always_comb begin
      rx_sel = '0;
      rx_vld = 1'b0;
      for (int k = 0; k <= MAX_LAT; k++) begin
         if (o_latency == LW'(k)) begin
            rx_sel = hist[k];
            rx_vld = vld_pipe[k];
         end
      end
   end

   assign mismatch = (state == RUN || state == DRAIN) && rx_vld && (rx_if.data != rx_sel);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (i_start) state_nxt = FLUSH;
         FLUSH:   if (cnt == LW'(MAX_LAT)) state_nxt = MEASURE;
         MEASURE: begin
            // the timeout test comes first so a latency of MAX_LAT+1 can never be latched
            if (cnt == LW'(MAX_LAT + 1)) state_nxt = DONE;
            else if (sync_seen)          state_nxt = RUN;
         end
         RUN:     if (wcnt == CW'(CHECK_LEN - 1)) state_nxt = DRAIN;
         DRAIN:   if (cnt == o_latency) state_nxt = DONE;
         DONE:    if (i_start) state_nxt = FLUSH;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs and the value loaded into the tx register at the next edge.
   // SYNC is loaded on the FLUSH->MEASURE edge so it is on the bus for the
   // first MEASURE cycle, i.e. when the latency counter is 0.
   always_comb begin
      o_busy  = !(state == IDLE || state == DONE);
      o_done  = (state == DONE);
      o_pass  = o_done && (o_err_cnt == 16'd0) && (o_latency <= LW'(MAX_LAT)) &&
                (!LAT_CHECK || o_latency == LW'(EXP_LAT));
      tx_nxt  = '0;
      vld_nxt = 1'b0;
      if (state == FLUSH && cnt == LW'(MAX_LAT)) tx_nxt = SYNC;
      if (state == RUN) begin
         tx_nxt  = lfsr;
         vld_nxt = 1'b1;
      end
   end

   // Datapath: history pipe, counters, LFSR, result registers.
   // cnt is shared: flush length, latency count, drain length.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hist      <= '0;
         vld_pipe  <= '0;
         lfsr      <= SEED_W;
         cnt       <= '0;
         wcnt      <= '0;
         o_latency <= '0;
         o_err_cnt <= '0;
      end else begin
         hist     <= {hist[MAX_LAT-1:0], tx_nxt};
         vld_pipe <= {vld_pipe[MAX_LAT-1:0], vld_nxt};
         if (mismatch && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
         unique case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  cnt       <= '0;
                  wcnt      <= '0;
                  lfsr      <= SEED_W;
                  o_latency <= '0;
                  o_err_cnt <= '0;
               end
            end
            FLUSH:   cnt <= (cnt == LW'(MAX_LAT)) ? '0 : cnt + 1'b1;
            MEASURE: begin
               if (cnt == LW'(MAX_LAT + 1)) begin
                  o_latency <= '1;
               end else if (sync_seen) begin
                  o_latency <= cnt;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               lfsr <= lfsr_nxt;
               wcnt <= wcnt + 1'b1;
            end
            DRAIN:   cnt <= cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dependency_loopback_tester.sv
// ---------------------------------------------------------------------------
// tb_dependency_loopback_tester
//   Loopback bench. A behavioural return path (two-stage delay, passthrough,
//   delay with one corrupted word, or stuck at zero) closes the loop. Each run
//   pushes its expected result into a scoreboard queue and the first 12 LFSR
//   words into a word queue; two monitors pop and compare when the DUT
//   raises o_done or starts streaming after SYNC.
// ---------------------------------------------------------------------------
module tb_dependency_loopback_tester;

   typedef struct packed {
      logic [4:0]  lat;
      logic [15:0] err;
      logic        pass;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        o_busy, o_done, o_pass;
   logic [4:0]  o_latency;
   logic [15:0] o_err_cnt;
   logic [7:0]  d1 = '0, d2 = '0, rx_val;
   int          loop_mode = 0;
   int          checks = 0, failures = 0;
   res_t        sb[$];
   logic [7:0]  wq[$];
   logic [7:0]  lfsr_tab [12];
   logic        done_d = 1'b0;
   int          ph = 0;
   logic        pass_pt;

   veryl_sample3_data_if #(.WIDTH(8)) tx_bus ();
   veryl_sample3_data_if #(.WIDTH(8)) rx_bus ();

   dependency_loopback_tester dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .tx_if     (tx_bus),
      .rx_if     (rx_bus),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_pass    (o_pass),
      .o_latency (o_latency),
      .o_err_cnt (o_err_cnt)
   );

   always #5 clk = ~clk;

   // return path models
   always @(posedge clk) begin
      d1 <= tx_bus.data;
      d2 <= d1;
   end

   always_comb begin
      case (loop_mode)
         1:       rx_val = tx_bus.data;
         2:       rx_val = d2 ^ {7'd0, (d2 == 8'h38)};  // 0x38 is the 10th word
         3:       rx_val = 8'h00;
         default: rx_val = d2;
      endcase
   end
   assign rx_bus.data = rx_val;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // result monitor: one pop per rising o_done
   always @(negedge clk) begin
      if (o_done && !done_d) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            res_t r;
            r = sb.pop_front();
            chk("latency", {27'd0, o_latency}, {27'd0, r.lat});
            chk("err_cnt", {16'd0, o_err_cnt}, {16'd0, r.err});
            chk("pass", {31'd0, o_pass}, {31'd0, r.pass});
            chk("busy_in_done", {31'd0, o_busy}, 0);
         end
      end
      done_d = o_done;
   end

   // stimulus monitor: after SYNC, the first nonzero words are the LFSR stream
   always @(negedge clk) begin
      case (ph)
         0: if (wq.size() > 0 && tx_bus.data == 8'hFF) ph = 1;
         1: if (tx_bus.data != 8'h00) begin
               chk("tx_word", {24'd0, tx_bus.data}, {24'd0, wq.pop_front()});
               ph = (wq.size() > 0) ? 2 : 0;
            end
         default: begin
               chk("tx_word", {24'd0, tx_bus.data}, {24'd0, wq.pop_front()});
               if (wq.size() == 0) ph = 0;
            end
      endcase
   end

   task automatic run_case(input string nm, input int mode, input logic [4:0] lat,
                           input logic [15:0] err, input logic pass, input bit words,
                           input int restart_at, input int cyc_exp);
      res_t r;
      int   n;
      loop_mode = mode;
      r.lat = lat; r.err = err; r.pass = pass;
      sb.push_back(r);
      if (words) foreach (lfsr_tab[i]) wq.push_back(lfsr_tab[i]);
      start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start = (n == restart_at);
         if (n == 5) chk({nm, "_busy"}, {31'd0, o_busy}, 1);
      end while (!o_done && n < 400);
      chk({nm, "_cycles"}, n, cyc_exp);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_state(input string nm);
      chk({nm, "_busy"}, {31'd0, o_busy}, 0);
      chk({nm, "_done"}, {31'd0, o_done}, 0);
      chk({nm, "_pass"}, {31'd0, o_pass}, 0);
      chk({nm, "_lat"}, {27'd0, o_latency}, 0);
      chk({nm, "_err"}, {16'd0, o_err_cnt}, 0);
      chk({nm, "_tx"}, {24'd0, tx_bus.data}, 0);
   endtask

   initial begin
      lfsr_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23,
                   8'h47, 8'h8E, 8'h1C, 8'h38, 8'h71, 8'hE2};
`ifdef DEPENDENCY_LOOPBACK_TESTER_LAT_CHECK_EN
      pass_pt = 1'b0;
`else
      pass_pt = 1'b1;
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_reset_state("reset");
      @(negedge clk);

      // 2-stage delay: 1 + 16 + 3 + 256 + 3 edges
      run_case("delay2", 0, 5'd2, 16'd0, 1'b1, 1'b1, 0, 279);
      // passthrough: latency 0
      run_case("passthru", 1, 5'd0, 16'd0, pass_pt, 1'b1, 0, 275);
      // one corrupted word
      run_case("corrupt", 2, 5'd2, 16'd1, 1'b0, 1'b1, 0, 279);
      // stuck at zero: timeout after the count reaches 16
      run_case("stuck0", 3, 5'h1F, 16'd0, 1'b0, 1'b0, 0, 34);

      // reset in the middle of RUN
      loop_mode = 0;
      foreach (lfsr_tab[i]) wq.push_back(lfsr_tab[i]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (69) @(negedge clk);
      chk("midrun_busy", {31'd0, o_busy}, 1);
      chk("midrun_lat", {27'd0, o_latency}, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_state("midrun_rst");
      @(negedge clk);
      run_case("after_rst", 0, 5'd2, 16'd0, 1'b1, 1'b1, 0, 279);

      // start pulse during RUN must be ignored
      run_case("restart_ignored", 0, 5'd2, 16'd0, 1'b1, 1'b1, 100, 279);

      chk("sb_empty", sb.size(), 0);
      chk("wq_empty", wq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dependency_loopback_tester.md
# dependency_loopback_tester

Self-checking loopback driver for `veryl_sample3_data_if` pipelines. It drives the producer end of a data interface into a device under test, observes the consumer end returned by that device, and measures the round-trip latency. It then streams an LFSR sequence and counts mismatches. It sits in the testcase tree beside the `veryl_sample1_delay` / `veryl_sample2_delay` chains, with `tx_if` wired to the chain's input and `rx_if` to its output.

## Interface
- `WIDTH`, 8: width of `data_if.data`; legal values 8, 16, 32.
- `MAX_LAT`, 15: largest latency accepted; history depth.
- `EXP_LAT`, 2: expected latency, used only with the configuration macro.
- `SEED`, 1: first LFSR word; nonzero.
- `CHECK_LEN`, 256: LFSR words sent and checked per run; must be at least 1.
- `i_clk`, in, 1: clock, rising edge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_start`, in, 1: single-cycle start request.
- `tx_if`, modport `veryl_sample3_data_if.mp_out`, `WIDTH`: stimulus; `data` is driven from a register.
- `rx_if`, modport `veryl_sample3_data_if.mp_in`, `WIDTH`: observed return stream.
- `o_busy`, out, 1: high in every state except IDLE and DONE.
- `o_done`, out, 1: high while in DONE.
- `o_pass`, out, 1: result; valid while `o_done` is high.
- `o_latency`, out, `$clog2(MAX_LAT+2)`: measured latency; all-ones on timeout.
- `o_err_cnt`, out, 16: mismatch count; saturates at 0xFFFF.

## Operation
- States: IDLE, FLUSH, MEASURE, RUN, DRAIN, DONE.
- Reset values: state IDLE, `tx_if.data` 0, `o_busy`/`o_done`/`o_pass` 0, `o_latency` 0, `o_err_cnt` 0, LFSR = `SEED`, history and valid pipeline cleared.
- IDLE: `tx_if.data` = 0. `i_start` moves to FLUSH and clears the counters and the LFSR.
- FLUSH: drive 0 for `MAX_LAT+1` cycles so the DUT pipeline holds zeros, then go to MEASURE.
- MEASURE:
  - On entry, `tx_if.data` = SYNC (all ones) for exactly one cycle, then 0.
  - The latency counter starts at 0 on the edge SYNC is launched (E0).
  - At each later edge, sample `rx_if.data`. If it equals SYNC, latch the counter into `o_latency` and go to RUN. Otherwise increment the counter.
  - If the counter reaches `MAX_LAT+1`: `o_latency` = all-ones, `o_pass` = 0, go to DONE.
- RUN:
  - Drive LFSR words: `SEED` first, then advance each cycle, `CHECK_LEN` words in total.
  - Polynomials: WIDTH 8 uses x^8+x^6+x^5+x^4+1; WIDTH 16 uses x^16+x^15+x^13+x^4+1; WIDTH 32 uses x^32+x^22+x^2+x+1.
  - A history shift register holds `hist[0]` = current `tx_if.data` and `hist[k]` = the value k cycles earlier, with a parallel valid bit per entry.
  - Each edge, if `valid[L]` is set, compare `rx_if.data` with `hist[L]`, where L = `o_latency`. On mismatch, increment `o_err_cnt` (saturating).
- DRAIN: drive 0 and keep comparing until L further edges have passed, so all `CHECK_LEN` words are compared. Then go to DONE.
- DONE: `o_done` = 1. `o_pass` = (`o_err_cnt` == 0) AND no timeout occurred. A new `i_start` restarts at FLUSH.
- `i_start` is ignored while `o_busy` is high.

## Timing
- `tx_if.data` is registered. SYNC and each LFSR word are visible one cycle after the state edge that selects them.
- A DUT with 2 register stages yields `o_latency` = 2. A combinational passthrough yields 0.
- Run length: 1 (start) + `MAX_LAT+1` + (L+2) + `CHECK_LEN` + L cycles, ±1. Defaults with L=2: about 279 cycles.
- `i_rst` asserted mid-run: the next edge returns to the full reset state; no partial result is kept.
- `i_start` coinciding with the DONE-entry edge is ignored. `o_done` must be seen high first.

## Configuration
- `DEPENDENCY_LOOPBACK_TESTER_LAT_CHECK_EN`
  - Defined: `o_pass` additionally requires `o_latency` == `EXP_LAT`.
  - Undefined: any latency from 0 to `MAX_LAT` passes; `EXP_LAT` is unused.

## Test plan
- Two-stage delay DUT, defaults, pulse `i_start` → `o_done` within 300 cycles, `o_latency`=2, `o_err_cnt`=0, `o_pass`=1.
- Combinational passthrough DUT → `o_latency`=0, `o_pass`=1 without the macro. With the macro and `EXP_LAT`=2 → `o_pass`=0, `o_err_cnt`=0.
- DUT that inverts bit 0 of the 10th word → `o_err_cnt`=1, `o_pass`=0.
- DUT output tied to 0 → timeout at count 16: `o_latency`=all-ones, `o_pass`=0, `o_done`=1.
- Assert `i_rst` for 1 cycle during RUN → all outputs return to reset values next cycle. A new `i_start` then gives `o_pass`=1.
- `i_start` pulsed during RUN → ignored; a single `o_done` arrives at the normal time with the same result.
